// File: rtl/ok_bt_pipe_out_fifo.sv
// ok_bt_pipe_out_fifo: buffered Block-Throttled Pipe Out endpoint.
// User logic pushes words into a show-ahead FIFO; the host drains fixed-length
// blocks. ok_ready is derived from the FIFO fill level. Shared host-bus outputs
// are driven to zero when the endpoint is not addressed, so they can be wire-ORed.
// Optional feature: define OK_BTPO_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun read counter on port underrun_cnt.
module ok_bt_pipe_out_fifo #(
  parameter logic [7:0] EP_ADDR    = 8'hA0,
  parameter int         DATA_WIDTH = 16,
  parameter int         DEPTH      = 1024,
  parameter int         BLOCK_LEN  = 256
) (
  input  logic                         ti_clk,
  input  logic                         ti_rst_n,
  input  logic [7:0]                   ti_addr,
  input  logic                         ti_read,
  input  logic                         ti_blockstrobe,
  output logic [DATA_WIDTH-1:0]        ok_dataout,
  output logic                         ok_ready,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         flag_clr,
  output logic [$clog2(DEPTH):0]       fill_count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underrun
`ifdef OK_BTPO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(BLOCK_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BLK_C   = CW'(BLOCK_LEN);
  localparam logic [RW-1:0] REM_C   = RW'(BLOCK_LEN);

  // Reject unsupported configurations at elaboration.
  if (EP_ADDR < 8'hA0 || EP_ADDR > 8'hBF) begin : g_bad_addr
    $fatal(1, "ok_bt_pipe_out_fifo: EP_ADDR outside 8'hA0..8'hBF");
  end
  if (DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "ok_bt_pipe_out_fifo: DATA_WIDTH must be 16 or 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ok_bt_pipe_out_fifo: DEPTH must be a power of two >= 2");
  end
  if (BLOCK_LEN < 1 || BLOCK_LEN > DEPTH) begin : g_bad_blk
    $fatal(1, "ok_bt_pipe_out_fifo: BLOCK_LEN must be within 1..DEPTH");
  end

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, empty_q;
  logic                    ovf_q, ovf_d, und_q, und_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic sel, rd_req, push, pop, ovf_evt, und_evt;

  // Host/user request decode; pops and underruns only count inside a block.
  always_comb begin
    sel     = (ti_addr == EP_ADDR);
    rd_req  = sel & ti_read & (state_q == ACTIVE);
    push    = wr_en & ~full_q;
    ovf_evt = wr_en & full_q;
    pop     = rd_req & ~empty_q;
    und_evt = rd_req & empty_q;
  end

  // Fill level and sticky flags (a new event beats flag_clr).
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~flag_clr) | ovf_evt;
    und_d = (und_q & ~flag_clr) | und_evt;
  end

  // FIFO pointers, level and status registers.
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  // Storage array; no reset so it can map onto RAM.
  always_ff @(posedge ti_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FSM state register with the remaining-words counter.
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // FSM next state; a strobe reloads the block even if a read lands with it.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (sel & ti_blockstrobe) begin
          state_d = ACTIVE;
          rem_d   = REM_C;
        end
      end
      ACTIVE: begin
        if (sel & ti_blockstrobe) begin
          rem_d = REM_C;
        end else if (rd_req) begin
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the head word is masked when empty so underrun reads give 0.
  always_comb begin
    ok_ready   = sel & (state_q == IDLE) & (count_q >= BLK_C);
    ok_dataout = (sel & ~empty_q) ? mem_q[rd_ptr_q] : '0;
  end

  assign fill_count = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = ovf_q;
  assign underrun   = und_q;

`ifdef OK_BTPO_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun counter; an underrun in the clear cycle counts as 1.
  always_comb begin
    ucnt_d = ucnt_q;
    if (und_evt) begin
      if (flag_clr)                ucnt_d = 16'd1;
      else if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end else if (flag_clr) begin
      ucnt_d = '0;
    end
  end

  // Underrun counter register.
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) ucnt_q <= '0;
    else           ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule
